block_lock_extractor: RTL and testbench

- Sits directly downstream of the hierarchical alignment seeker in the RD53B Aurora 64b/66b receive path.
- Takes the seeker's offset_pos and is_synced, slices one 66-bit block out of the same gearbox buffer, and checks its sync header.
- Runs a block-lock state machine with hysteresis.
- Emits 64-bit payload, 2-bit header and a lock flag, plus a saturating lock-loss counter for SEE logging.

---
 rtl/aurora_rx_pkg.sv | 20 ++
 rtl/block_slicer.sv | 15 +
 rtl/block_lock_extractor.sv | 154 +++++++++++++++
 tb/tb_block_lock_extractor.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_rx_pkg.sv
// Shared types and constants for the Aurora 64b/66b receive path.
package aurora_rx_pkg;

    localparam int unsigned BLOCK_W   = 66;
    localparam int unsigned BUF_W     = 194;
    localparam logic [1:0]  SYNC_DATA = 2'b01;
    localparam logic [1:0]  SYNC_CTRL = 2'b10;

    typedef enum logic [1:0] {
        HUNT,
        CHECK,
        LOCKED
    } lock_state_t;

    // Only the two transition patterns are legal sync headers.
    function automatic logic hdr_valid(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/block_slicer.sv
// Extracts one 66-bit block from the gearbox buffer at a given bit offset.
module block_slicer
    import aurora_rx_pkg::*;
(
    input  logic [BUF_W-1:0]   gbox_buffer,
    input  logic [6:0]         off,
    output logic [BLOCK_W-1:0] block
);

    // Right shift then truncate; any 7-bit offset stays inside the buffer.
    always_comb begin
        block = BLOCK_W'(gbox_buffer >> off);
    end

endmodule

// File: rtl/block_lock_extractor.sv
// Block-lock FSM with hysteresis downstream of the alignment seeker.
module block_lock_extractor
    import aurora_rx_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 32,
    parameter int unsigned WINDOW     = 64,
    parameter int unsigned UNLOCK_BAD = 16,
    parameter int unsigned MAX_POS    = 65
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [BUF_W-1:0] gbox_buffer,
    input  logic             buffer_dv,
    input  logic             is_synced,
    input  logic [6:0]       offset_pos,
    output logic [63:0]      data_o,
    output logic [1:0]       header_o,
    output logic             data_valid_o,
    output logic             block_lock_o,
    output logic [7:0]       lock_loss_cnt_o
);

    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned WIN_W  = $clog2(WINDOW + 1);
    localparam int unsigned BAD_W  = $clog2(UNLOCK_BAD + 1);

    lock_state_t        state_q, state_d;
    logic [6:0]         off_q, off_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [BAD_W-1:0]   bad_q, bad_d;
    logic [7:0]         loss_q, loss_d;
    logic [63:0]        data_q, data_d;
    logic [1:0]         hdr_q, hdr_d;
    logic               dvalid_q, dvalid_d;

    logic [6:0]         slice_off;
    logic [BLOCK_W-1:0] block;
    logic               synced;
    logic               hv;
    logic [BAD_W-1:0]   bad_inc;

    // Offset is frozen once locked so seeker wander cannot disturb a good lock.
    assign slice_off = (state_q == LOCKED) ? off_q : offset_pos;
    // Out-of-range offsets are treated as loss of seeker sync.
    assign synced    = is_synced && (offset_pos <= 7'(MAX_POS));
    assign hv        = hdr_valid(block[65:64]);
    assign bad_inc   = bad_q + BAD_W'(!hv);

    block_slicer u_slicer (
        .gbox_buffer (gbox_buffer),
        .off         (slice_off),
        .block       (block)
    );

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= HUNT;
            off_q   <= '0;
            good_q  <= '0;
            win_q   <= '0;
            bad_q   <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            good_q  <= good_d;
            win_q   <= win_d;
            bad_q   <= bad_d;
            loss_q  <= loss_d;
        end
    end

    // Next-state and counter updates; everything holds when buffer_dv is low.
    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        good_d  = good_q;
        win_d   = win_q;
        bad_d   = bad_q;
        loss_d  = loss_q;
        if (buffer_dv) begin
            unique case (state_q)
                HUNT: begin
                    if (synced) begin
                        off_d   = offset_pos;
                        good_d  = '0;
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (!synced) begin
                        state_d = HUNT;
                    end else if (offset_pos != off_q) begin
                        // New candidate alignment: restart the count, ignore this header.
                        off_d  = offset_pos;
                        good_d = '0;
                    end else if (!hv) begin
                        state_d = HUNT;
                    end else if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
                        state_d = LOCKED;
                        win_d   = '0;
                        bad_d   = '0;
                    end else begin
                        good_d = good_q + GOOD_W'(1);
                    end
                end
                LOCKED: begin
                    if (!synced || (bad_inc == BAD_W'(UNLOCK_BAD))) begin
                        state_d = HUNT;
                        if (loss_q != 8'hFF) begin
                            loss_d = loss_q + 8'd1;
                        end
                    end else if (win_q == WIN_W'(WINDOW - 1)) begin
                        win_d = '0;
                        bad_d = '0;
                    end else begin
                        win_d = win_q + WIN_W'(1);
                        bad_d = bad_inc;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Output next values: payload refreshed on every dv, valid only for locked blocks.
    always_comb begin
        data_d   = buffer_dv ? block[63:0] : data_q;
        hdr_d    = buffer_dv ? block[65:64] : hdr_q;
        dvalid_d = buffer_dv && (state_q == LOCKED);
    end

    // Output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q   <= '0;
            hdr_q    <= '0;
            dvalid_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            hdr_q    <= hdr_d;
            dvalid_q <= dvalid_d;
        end
    end

    assign data_o          = data_q;
    assign header_o        = hdr_q;
    assign data_valid_o    = dvalid_q;
    assign block_lock_o    = (state_q == LOCKED);
    assign lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_block_lock_extractor.sv
// Randomized bench for block_lock_extractor against a behavioural model.
module tb_block_lock_extractor;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [193:0] gbox_buffer;
    logic         buffer_dv;
    logic         is_synced;
    logic [6:0]   offset_pos;
    logic [63:0]  data_o;
    logic [1:0]   header_o;
    logic         data_valid_o;
    logic         block_lock_o;
    logic [7:0]   lock_loss_cnt_o;

    int n_total = 0;
    int n_bad   = 0;

    // Model: 0 = hunting, 1 = counting good headers, 2 = locked.
    int          m_mode, m_off, m_good, m_win, m_bad, m_loss;
    logic [63:0] m_data;
    logic [1:0]  m_hdr;
    logic        m_dv;

    block_lock_extractor dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .gbox_buffer     (gbox_buffer),
        .buffer_dv       (buffer_dv),
        .is_synced       (is_synced),
        .offset_pos      (offset_pos),
        .data_o          (data_o),
        .header_o        (header_o),
        .data_valid_o    (data_valid_o),
        .block_lock_o    (block_lock_o),
        .lock_loss_cnt_o (lock_loss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [193:0] make_buf(input int pos, input logic [1:0] hdr);
        logic [193:0] b;
        b = '0;
        for (int i = 0; i < 7; i++) b = {b[161:0], 32'($urandom())};
        b[pos + 64 +: 2] = hdr;
        return b;
    endfunction

    function automatic logic [1:0] pick_hdr(input bit good);
        return good ? 2'($urandom_range(1, 2)) : (($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_off = 0; m_good = 0; m_win = 0; m_bad = 0; m_loss = 0;
        m_data = '0; m_hdr = '0; m_dv = 1'b0;
    endtask

    task automatic model_lose();
        m_mode = 0;
        if (m_loss < 255) m_loss++;
    endtask

    task automatic model_step(input bit dv, input bit syn_in, input int pos, input logic [193:0] b);
        int         off;
        logic [65:0] blk;
        bit         syn, hv;
        m_dv = dv && (m_mode == 2);
        if (!dv) return;
        off = (m_mode == 2) ? m_off : pos;
        for (int i = 0; i < 66; i++) blk[i] = b[off + i];
        m_data = blk[63:0];
        m_hdr  = blk[65:64];
        syn = syn_in && (pos <= 65);
        hv  = (m_hdr == 2'b01) || (m_hdr == 2'b10);
        case (m_mode)
            0: if (syn) begin m_off = pos; m_good = 0; m_mode = 1; end
            1: begin
                if (!syn) m_mode = 0;
                else if (pos != m_off) begin m_off = pos; m_good = 0; end
                else if (!hv) m_mode = 0;
                else begin
                    m_good++;
                    if (m_good == 32) begin m_mode = 2; m_win = 0; m_bad = 0; end
                end
            end
            default: begin
                if (!syn) model_lose();
                else begin
                    if (!hv) m_bad++;
                    if (m_bad == 16) model_lose();
                    else begin
                        m_win++;
                        if (m_win == 64) begin m_win = 0; m_bad = 0; end
                    end
                end
            end
        endcase
    endtask

    task automatic check_all();
        check_eq("data", data_o, m_data);
        check_eq("header", 64'(header_o), 64'(m_hdr));
        check_eq("data_valid", 64'(data_valid_o), 64'(m_dv));
        check_eq("block_lock", 64'(block_lock_o), 64'(m_mode == 2));
        check_eq("loss_cnt", 64'(lock_loss_cnt_o), 64'(m_loss));
    endtask

    task automatic step(input bit dv, input bit syn, input int pos, input logic [193:0] b);
        @(negedge clk_i);
        buffer_dv   = dv;
        is_synced   = syn;
        offset_pos  = 7'(pos);
        gbox_buffer = b;
        model_step(dv, syn, pos, b);
        @(posedge clk_i);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        buffer_dv = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        check_all();
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic acquire(input int pos);
        for (int i = 0; i < 33; i++) step(1, 1, pos, make_buf(pos, 2'b01));
    endtask

    logic [193:0] b;

    initial begin
        rst_ni = 1'b0; buffer_dv = 1'b0; is_synced = 1'b0; offset_pos = '0; gbox_buffer = '0;
        do_reset();

        // Idle: unsynced dv keeps HUNT and zero outputs.
        for (int i = 0; i < 3; i++) step(1, 0, 17, '0);
        check_eq("idle_lock", 64'(block_lock_o), 64'd0);

        // Acquire at offset 17: lock rises exactly after the 33rd block.
        for (int i = 0; i < 32; i++) step(1, 1, 17, make_buf(17, 2'b01));
        check_eq("pre_lock", 64'(block_lock_o), 64'd0);
        step(1, 1, 17, make_buf(17, 2'b01));
        check_eq("lock_rise", 64'(block_lock_o), 64'd1);
        check_eq("no_dv_entry", 64'(data_valid_o), 64'd0);
        b = make_buf(17, 2'b01);
        step(1, 1, 17, b);
        check_eq("first_dv", 64'(data_valid_o), 64'd1);
        check_eq("first_data", data_o, b[80:17]);

        // Offset freeze: seeker moves to 3, data still from 17.
        b = make_buf(17, 2'b10);
        step(1, 1, 3, b);
        check_eq("freeze_data", data_o, b[80:17]);
        check_eq("freeze_lock", 64'(block_lock_o), 64'd1);

        // Sync drop for one dv.
        step(1, 0, 17, make_buf(17, 2'b01));
        check_eq("drop_lock", 64'(block_lock_o), 64'd0);
        check_eq("drop_loss", 64'(lock_loss_cnt_o), 64'd1);

        // CHECK restart on offset change.
        do_reset();
        for (int i = 0; i < 21; i++) step(1, 1, 17, make_buf(17, 2'b01));
        for (int i = 0; i < 32; i++) step(1, 1, 40, make_buf(40, 2'b10));
        check_eq("restart_pre", 64'(block_lock_o), 64'd0);
        step(1, 1, 40, make_buf(40, 2'b01));
        check_eq("restart_lock", 64'(block_lock_o), 64'd1);

        // Bad header in CHECK drops to HUNT.
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 1, 17, make_buf(17, 2'b01));
        step(1, 1, 17, make_buf(17, 2'b11));
        for (int i = 0; i < 32; i++) step(1, 1, 17, make_buf(17, 2'b01));
        check_eq("check_bad", 64'(block_lock_o), 64'd0);

        // Hysteresis: 15 bad in a window holds, 16 drops.
        do_reset();
        acquire(17);
        for (int i = 0; i < 64; i++) step(1, 1, 17, make_buf(17, pick_hdr(i >= 15)));
        check_eq("hyst15", 64'(block_lock_o), 64'd1);
        for (int i = 0; i < 16; i++) step(1, 1, 17, make_buf(17, pick_hdr(0)));
        check_eq("hyst16_lock", 64'(block_lock_o), 64'd0);
        check_eq("hyst16_loss", 64'(lock_loss_cnt_o), 64'd1);
        // 8 bad at the end of one window and 8 at the start of the next.
        acquire(17);
        for (int i = 0; i < 128; i++)
            step(1, 1, 17, make_buf(17, pick_hdr(!((i >= 56) && (i < 72)))));
        check_eq("hyst_split", 64'(block_lock_o), 64'd1);

        // Offset edge cases.
        do_reset();
        acquire(65);
        b = make_buf(65, 2'b01);
        step(1, 1, 65, b);
        check_eq("pos65_data", data_o, b[128:65]);
        check_eq("pos65_hdr", 64'(header_o), 64'd1);
        step(1, 1, 66, make_buf(65, 2'b01));
        check_eq("pos66_unlock", 64'(block_lock_o), 64'd0);
        for (int i = 0; i < 40; i++) step(1, 1, 66, make_buf(66, 2'b01));
        check_eq("pos66_hunt", 64'(block_lock_o), 64'd0);

        // Mid-operation asynchronous reset.
        acquire(17);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #2;
        model_reset();
        check_all();
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) step(1, 1, 17, make_buf(17, 2'b01));

        // Randomized traffic with varying error rates.
        do_reset();
        begin
            int pos = 17;
            int bad_pct = 0;
            for (int i = 0; i < 3000; i++) begin
                if (i % 200 == 0) bad_pct = (i / 200) % 3 == 0 ? 0 : ((i / 200) % 3 == 1 ? 5 : 25);
                if ($urandom_range(0, 99) < 2) pos = $urandom_range(0, 99) < 10 ?
                    $urandom_range(66, 127) : $urandom_range(0, 65);
                step($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 98, pos,
                     make_buf(pos, pick_hdr($urandom_range(0, 99) >= bad_pct)));
            end
        end

        // Loss counter saturation.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            acquire(17);
            step(1, 0, 17, make_buf(17, 2'b01));
        end
        check_eq("loss_sat", 64'(lock_loss_cnt_o), 64'd255);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
